vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
// Parametrised VGA raster timing generator with pipeline-aligned sync/blank outputs.
// - Raw x/y counters drive the frame-buffer read address.
// - h_sync, v_sync, sync_b and blank_b are delayed by LEAD cycles so they align
//   with pixel data returned from a memory of LEAD-cycle read latency.
// - Adds count enable, programmable sync polarity, and frame/line start strobes.
// - Sits between the pixel clock divider and the DAC/colour path.
// PARAMETERS
// H_ACTIVE  256  visible pixels per line
// H_FP      192  horizontal front porch, pixels
// H_SYNC    48   horizontal sync width, pixels
// H_BP      192  horizontal back porch, pixels
// V_ACTIVE  256  visible lines per frame
// V_FP      112  vertical front porch, lines
// V_SYNC    2    vertical sync width, lines
// V_BP      112  vertical back porch, lines
// HS_POL    0    h_sync asserted level (0 = active-low)
// VS_POL    0    v_sync asserted level (0 = active-low)
// LEAD      2    pipeline delay of sync/blank vs x/y; legal 1..8
// CW        10   counter width; requires HMAX-1 and VMAX-1 < 2**CW
// PORTS
// vga_clk      in   1   pixel clock
// rst_n        in   1   async active-low reset
// en           in   1   count enable; 0 freezes counters and delay pipeline
// x            out  CW  horizontal counter (read address, undelayed)
// y            out  CW  vertical counter (read address, undelayed)
// fetch_valid  out  1   (x<H_ACTIVE)&&(y<V_ACTIVE), undelayed
// line_start   out  1   x==0 && en
// frame_start  out  1   x==0 && y==0 && en
// h_sync       out  1   horizontal sync at HS_POL level, LEAD-delayed
// v_sync       out  1   vertical sync at VS_POL level, LEAD-delayed
// sync_b       out  1   active-low composite: ~(hs_active|vs_active), LEAD-delayed
// blank_b      out  1   1 inside visible area, LEAD-delayed
// BEHAVIOUR
// - HMAX = H_ACTIVE+H_FP+H_SYNC+H_BP; VMAX = V_ACTIVE+V_FP+V_SYNC+V_BP. Defaults: 688, 482.
// - Segment order per axis: ACTIVE, FP, SYNC, BP.
// - hs_active = x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vs_active likewise for y.
// - Reset (async assert, sync release):
//   - x=0, y=0.
//   - All LEAD pipeline stages hold hs_active=0, vs_active=0, blank_b=0.
//   - After reset: h_sync=~HS_POL, v_sync=~VS_POL, sync_b=1, blank_b=0.
// - Counting on each vga_clk edge with en=1:
//   - x increments.
//   - At x==HMAX-1: x wraps to 0 and y increments.
//   - When x==HMAX-1 and y==VMAX-1: both wrap to 0 on the same edge.
// - en=0: x, y and all pipeline stages hold. Strobes are 0.
//   Delayed outputs keep their last values.
// - Pipeline: stage0 samples {hs_active, vs_active, visible} computed from the
//   current x/y. Outputs are taken from stage LEAD-1, so the decode for counter
//   value N appears LEAD enabled cycles after x/y==N.
// - Output polarity: h_sync = hs_active ? HS_POL : ~HS_POL (v_sync likewise).
// - sync_b is independent of HS_POL/VS_POL.
// - Strobes are combinational from the registered counters. frame_start implies line_start.
// - Reset mid-frame: immediate return to the reset state, with no partial sync pulse
//   held. The next frame starts at (0,0).
// - No arithmetic overflow: counters compare against HMAX-1/VMAX-1 before wrap.
//   CW is checked by an elaboration-time assertion.
// TESTING
// - Reset, then en=1 for 1 cycle -> frame_start=1, line_start=1 at x=0,y=0;
//   h_sync=1, v_sync=1, blank_b=0 for the first 2 cycles.
// - Run one line -> x reaches 687, then x=0, y=1. h_sync low when x in [450,498)
//   (LEAD=2 shift). blank_b high when x in [2,258) of line 1.
// - Run a full frame -> y wraps 481->0 together with x 687->0. v_sync low for
//   2 lines after y reaches 368 (+2-pixel lag). Exactly one frame_start per 688*482 cycles.
// - Toggle en low for 10 cycles at x=300 -> x stays 300 and outputs are frozen;
//   resume -> sequence continues with no lost or duplicated pixel.
// - HS_POL=1, VS_POL=1 -> sync pulses inverted (high during sync); sync_b unchanged.
// - Assert rst_n low at x=470,y=369 (mid h- and v-sync) -> outputs immediately
//   return to reset values; after release the count restarts at 0,0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: undelayed x/y counters for frame-buffer addressing,
// with sync/blank decode delayed LEAD cycles to line up with returned pixel data.
module vga_timing_gen #(
    parameter int H_ACTIVE = 256,
    parameter int H_FP     = 192,
    parameter int H_SYNC   = 48,
    parameter int H_BP     = 192,
    parameter int V_ACTIVE = 256,
    parameter int V_FP     = 112,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 112,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int LEAD     = 2,
    parameter int CW       = 10
) (
    input  logic          vga_clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          fetch_valid,
    output logic          line_start,
    output logic          frame_start,
    output logic          h_sync,
    output logic          v_sync,
    output logic          sync_b,
    output logic          blank_b
);

    localparam int HMAX = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VMAX = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] X_LAST = CW'(HMAX - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(VMAX - 1);
    // One extra bit so segment bounds equal to 2**CW (zero back porch) stay exact.
    localparam logic [CW:0] H_VIS  = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] HS_BEG = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0] HS_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0] V_VIS  = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0] VS_BEG = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0] VS_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

    if ((HMAX - 1) >= (2 ** CW) || (VMAX - 1) >= (2 ** CW)) begin : g_cw_check
        $error("vga_timing_gen: CW too small for HMAX/VMAX");
    end
    if (LEAD < 1 || LEAD > 8) begin : g_lead_check
        $error("vga_timing_gen: LEAD must be in 1..8");
    end

    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    // Each stage holds {hs_active, vs_active, visible}.
    logic [2:0]    pipe_q [LEAD];
    logic [2:0]    pipe_d [LEAD];
    logic          hs_act, vs_act, visible;
    logic [2:0]    tap;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (en) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + CW'(1);
            end else begin
                x_d = x_q + CW'(1);
            end
        end
    end

    always_comb begin
        hs_act  = ({1'b0, x_q} >= HS_BEG) && ({1'b0, x_q} < HS_END);
        vs_act  = ({1'b0, y_q} >= VS_BEG) && ({1'b0, y_q} < VS_END);
        visible = ({1'b0, x_q} < H_VIS) && ({1'b0, y_q} < V_VIS);
    end

    always_comb begin
        pipe_d = pipe_q;
        if (en) begin
            pipe_d[0] = {hs_act, vs_act, visible};
            for (int i = 1; i < LEAD; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
            for (int i = 0; i < LEAD; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            for (int i = 0; i < LEAD; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign tap         = pipe_q[LEAD-1];
    assign x           = x_q;
    assign y           = y_q;
    assign fetch_valid = visible;
    assign line_start  = (x_q == '0) && en;
    assign frame_start = (x_q == '0) && (y_q == '0) && en;
    assign h_sync      = tap[2] ? HS_POL : ~HS_POL;
    assign v_sync      = tap[1] ? VS_POL : ~VS_POL;
    assign sync_b      = ~(tap[2] | tap[1]);
    assign blank_b     = tap[0];

endmodule
